// File: rtl/rtc_bus_burst_ctrl_pkg.sv
// Shared definitions for the RTC multiplexed-bus burst controller:
// FSM encodings, operation codes and strobe levels.
package rtc_bus_burst_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_PULSE = 3'd1,
    ST_ADDR_GAP   = 3'd2,
    ST_DATA_PULSE = 3'd3,
    ST_DATA_GAP   = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  localparam logic OP_WRITE      = 1'b0;
  localparam logic OP_READ       = 1'b1;
  localparam logic STROBE_IDLE   = 1'b1;
  localparam logic STROBE_ACTIVE = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rtc_bus_io.sv
// Tristate pad driver for the RTC AD bus, with a registered capture of the
// incoming bus value used for reads.
module rtc_bus_io #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         drive_en,
  input  logic [N-1:0] dout,
  input  logic         capture_en,
  output logic [N-1:0] din,
  inout  wire  [N-1:0] salient
);

  assign salient = drive_en ? dout : {N{1'bz}};

  // Capture happens while the RTC still drives the bus (RD still low).
  always_ff @(posedge clk) begin
    if (reset) begin
      din <= '0;
    end else if (capture_en) begin
      din <= salient;
    end
  end

endmodule

// File: rtl/rtc_bus_burst_ctrl.sv
// Burst read/write controller for the RTC multiplexed address/data bus.
// All outputs are registered and decoded from the next FSM state.
module rtc_bus_burst_ctrl
  import rtc_bus_burst_ctrl_pkg::*;
#(
  parameter int N       = 8,
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [N-1:0]     addr,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [N-1:0]     wdata,
  output logic             wdata_ack,
  output logic [N-1:0]     rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             AD,
  output logic             CS,
  output logic             WR,
  output logic             RD,
  inout  wire  [N-1:0]     salient
);

  localparam int TW = $clog2(max2(T_PULSE, T_GAP) + 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(T_PULSE - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(T_GAP - 1);

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [N-1:0]     cur_addr, cur_addr_nxt;
  logic             op_q, op_nxt;
  logic [N-1:0]     dout_q, dout_nxt;
  logic             drive_q, drive_nxt;
  logic             ad_nxt, cs_nxt, wr_nxt, rd_nxt;
  logic             busy_nxt, done_nxt, ack_nxt, capture_en;
  logic             timer_done;

  assign timer_done = (timer == '0);

  // Next-state, phase timer, burst bookkeeping and next-cycle output decode.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer_done ? timer : timer - 1'b1;
    remaining_nxt = remaining;
    cur_addr_nxt  = cur_addr;
    op_nxt        = op_q;
    dout_nxt      = dout_q;
    capture_en    = 1'b0;
    ack_nxt       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt     = ST_ADDR_PULSE;
          timer_nxt     = PULSE_LOAD;
          op_nxt        = op;
          cur_addr_nxt  = addr;
          dout_nxt      = addr;
          remaining_nxt = (burst_len == '0) ? '0 : burst_len - 1'b1;
        end
      end
      ST_ADDR_PULSE: begin
        if (timer_done) begin
          state_nxt = ST_ADDR_GAP;
          timer_nxt = GAP_LOAD;
        end
      end
      ST_ADDR_GAP: begin
        if (timer_done) begin
          state_nxt = ST_DATA_PULSE;
          timer_nxt = PULSE_LOAD;
          dout_nxt  = wdata;
          ack_nxt   = (op_q == OP_WRITE);
        end
      end
      ST_DATA_PULSE: begin
        if (timer_done) begin
          state_nxt  = ST_DATA_GAP;
          timer_nxt  = GAP_LOAD;
          capture_en = (op_q == OP_READ);
        end
      end
      ST_DATA_GAP: begin
        if (timer_done) begin
          if (remaining == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt     = ST_ADDR_PULSE;
            timer_nxt     = PULSE_LOAD;
            remaining_nxt = remaining - 1'b1;
            cur_addr_nxt  = cur_addr + 1'b1;
            dout_nxt      = cur_addr + 1'b1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    ad_nxt    = STROBE_IDLE;
    cs_nxt    = STROBE_IDLE;
    wr_nxt    = STROBE_IDLE;
    rd_nxt    = STROBE_IDLE;
    drive_nxt = 1'b0;
    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);

    case (state_nxt)
      ST_ADDR_PULSE: begin
        ad_nxt    = STROBE_ACTIVE;
        cs_nxt    = STROBE_ACTIVE;
        wr_nxt    = STROBE_ACTIVE;
        drive_nxt = 1'b1;
      end
      ST_DATA_PULSE: begin
        cs_nxt = STROBE_ACTIVE;
        if (op_nxt == OP_WRITE) begin
          wr_nxt    = STROBE_ACTIVE;
          drive_nxt = 1'b1;
        end else begin
          rd_nxt = STROBE_ACTIVE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      remaining   <= '0;
      cur_addr    <= '0;
      op_q        <= OP_WRITE;
      dout_q      <= '0;
      drive_q     <= 1'b0;
      AD          <= STROBE_IDLE;
      CS          <= STROBE_IDLE;
      WR          <= STROBE_IDLE;
      RD          <= STROBE_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wdata_ack   <= 1'b0;
      rdata_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      remaining   <= remaining_nxt;
      cur_addr    <= cur_addr_nxt;
      op_q        <= op_nxt;
      dout_q      <= dout_nxt;
      drive_q     <= drive_nxt;
      AD          <= ad_nxt;
      CS          <= cs_nxt;
      WR          <= wr_nxt;
      RD          <= rd_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      wdata_ack   <= ack_nxt;
      rdata_valid <= capture_en;
    end
  end

  rtc_bus_io #(.N(N)) u_io (
    .clk        (clk),
    .reset      (reset),
    .drive_en   (drive_q),
    .dout       (dout_q),
    .capture_en (capture_en),
    .din        (rdata),
    .salient    (salient)
  );

endmodule

// File: tb/tb_rtc_bus_burst_ctrl.sv
// Self-checking bench for rtc_bus_burst_ctrl: an RTC register-file model on the
// bus, scoreboard queues for bus addresses, write bytes and read data.
module tb_rtc_bus_burst_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [3:0] burst_len = 4'h0;
  logic [7:0] wdata;
  logic       wdata_ack, rdata_valid, busy, done;
  logic       AD, CS, WR, RD;
  logic [7:0] rdata;
  wire  [7:0] salient;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;
  int rv_seen = 0;
  logic width_en = 1'b1;

  logic [7:0] exp_addr[$];
  logic [7:0] exp_wdata[$];
  logic [7:0] exp_rdata[$];
  logic [7:0] wsrc[$];

  logic [7:0] model_mem [0:255];
  logic [7:0] model_addr = 8'h00;
  logic       model_ready = 1'b0;
  logic       tb_drive;
  logic [7:0] tb_dout;

  rtc_bus_burst_ctrl #(.N(8), .T_PULSE(4), .T_GAP(2), .LEN_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .addr        (addr),
    .burst_len   (burst_len),
    .wdata       (wdata),
    .wdata_ack   (wdata_ack),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .done        (done),
    .AD          (AD),
    .CS          (CS),
    .WR          (WR),
    .RD          (RD),
    .salient     (salient)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // The RTC drives its addressed register whenever a read strobe is active.
  assign tb_drive = (CS == 1'b0) && (AD == 1'b1) && (RD == 1'b0);
  assign tb_dout  = model_mem[model_addr];
  assign salient  = tb_drive ? tb_dout : 8'bzzzz_zzzz;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (salient[g]);
  end

  // RTC register-file model: latch address on AD low, store on WR data phase.
  always @(negedge clk) begin
    if (!model_ready) begin
      for (int a = 0; a < 256; a++) model_mem[a] = 8'(~a);
      model_ready = 1'b1;
    end
    if (CS == 1'b0 && AD == 1'b0) model_addr = salient;
    if (CS == 1'b0 && AD == 1'b1 && WR == 1'b0) model_mem[model_addr] = salient;
  end

  // Write-data source: present the next byte after each wdata_ack.
  logic [7:0] wtmp;
  always @(negedge clk) begin
    if (wdata_ack && wsrc.size() > 0) wtmp = wsrc.pop_front();
    wdata = (wsrc.size() > 0) ? wsrc[0] : 8'h00;
  end

  // Bus monitor: scoreboard pops plus continuous strobe/bus rules.
  logic prev_ad = 1'b1;
  logic prev_wrd = 1'b0;
  int   last_rv = -1;
  int   wr_cnt = 0, rd_cnt = 0, ad_cnt = 0;
  logic [7:0] e;
  always @(negedge clk) begin
    if (AD == 1'b0 && prev_ad == 1'b1) begin
      tests++;
      if (exp_addr.size() == 0) begin
        fails++;
        $display("[TB] FAIL addr_phase: unexpected address phase, bus=%h", salient);
      end else begin
        e = exp_addr.pop_front();
        if (salient !== e) begin
          fails++;
          $display("[TB] FAIL addr_phase: bus=%h expected=%h", salient, e);
        end
      end
    end
    if ((CS == 1'b0 && AD == 1'b1 && WR == 1'b0) && !prev_wrd) begin
      tests++;
      if (exp_wdata.size() == 0) begin
        fails++;
        $display("[TB] FAIL write_data: unexpected write phase, bus=%h", salient);
      end else begin
        e = exp_wdata.pop_front();
        if (salient !== e) begin
          fails++;
          $display("[TB] FAIL write_data: bus=%h expected=%h", salient, e);
        end
      end
    end
    if (rdata_valid === 1'b1) begin
      rv_seen++;
      tests++;
      if (exp_rdata.size() == 0) begin
        fails++;
        $display("[TB] FAIL read_data: unexpected rdata_valid, rdata=%h", rdata);
      end else begin
        e = exp_rdata.pop_front();
        if (rdata !== e) begin
          fails++;
          $display("[TB] FAIL read_data: rdata=%h expected=%h", rdata, e);
        end
      end
      if (last_rv >= 0) begin
        tests++;
        if (cyc - last_rv != 12) begin
          fails++;
          $display("[TB] FAIL read_spacing: got %0d cycles expected 12", cyc - last_rv);
        end
      end
      last_rv = cyc;
    end
    if (done === 1'b1) begin
      done_seen++;
      last_rv = -1;
    end
    if (WR == 1'b0 || RD == 1'b0) begin
      tests++;
      if (CS !== 1'b0 || (WR == 1'b0 && RD == 1'b0)) begin
        fails++;
        $display("[TB] FAIL strobe_combo: CS=%b WR=%b RD=%b expected CS=0 and one strobe", CS, WR, RD);
      end
    end
    if (RD == 1'b0) begin
      tests++;
      if (salient !== tb_dout) begin
        fails++;
        $display("[TB] FAIL read_contention: bus=%h expected RTC value %h", salient, tb_dout);
      end
    end
    if (!width_en) begin
      wr_cnt = 0; rd_cnt = 0; ad_cnt = 0;
    end else begin
      if (WR == 1'b0) wr_cnt++;
      else if (wr_cnt > 0) begin
        tests++;
        if (wr_cnt != 4) begin
          fails++;
          $display("[TB] FAIL wr_width: got %0d expected 4", wr_cnt);
        end
        wr_cnt = 0;
      end
      if (RD == 1'b0) rd_cnt++;
      else if (rd_cnt > 0) begin
        tests++;
        if (rd_cnt != 4) begin
          fails++;
          $display("[TB] FAIL rd_width: got %0d expected 4", rd_cnt);
        end
        rd_cnt = 0;
      end
      if (AD == 1'b0) ad_cnt++;
      else if (ad_cnt > 0) begin
        tests++;
        if (ad_cnt != 4) begin
          fails++;
          $display("[TB] FAIL ad_width: got %0d expected 4", ad_cnt);
        end
        ad_cnt = 0;
      end
    end
    prev_ad  = AD;
    prev_wrd = (CS == 1'b0 && AD == 1'b1 && WR == 1'b0);
  end

  // Pulses start for one cycle, then scrambles the latched-at-start inputs.
  task automatic issue_start(input logic o, input logic [7:0] a, input logic [3:0] l);
    @(negedge clk);
    start = 1'b1; op = o; addr = a; burst_len = l;
    @(negedge clk);
    start = 1'b0; op = ~o; addr = 8'($urandom); burst_len = 4'($urandom);
  endtask

  // Counts cycles from the first busy cycle to done; -1 on timeout.
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({AD, CS, WR, RD, busy, done, wdata_ack, rdata_valid} !== 8'b1111_0000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected 11110000",
               {AD, CS, WR, RD, busy, done, wdata_ack, rdata_valid});
    end
    tests++;
    if (rdata !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_rdata: got %h expected 00", rdata);
    end
    tests++;
    if (salient !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL reset_bus: got %h expected released (ff)", salient);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int n;
    wsrc.push_back(8'h5A);
    exp_addr.push_back(8'h21);
    exp_wdata.push_back(8'h5A);
    issue_start(1'b0, 8'h21, 4'd1);
    tests++;
    if (busy !== 1'b1 || AD !== 1'b0) begin
      fails++;
      $display("[TB] FAIL write1_first_cycle: busy=%b AD=%b expected 1 0", busy, AD);
    end
    wait_done(n);
    tests++;
    if (n != 13) begin
      fails++;
      $display("[TB] FAIL write1_latency: done at k+%0d expected k+13", n);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL write1_after_done: done=%b busy=%b expected 0 0", done, busy);
    end
    tests++;
    if (model_mem[8'h21] !== 8'h5A) begin
      fails++;
      $display("[TB] FAIL write1_reg: reg[21]=%h expected 5a", model_mem[8'h21]);
    end
  endtask

  task automatic test_read_burst();
    int n, rv0;
    rv0 = rv_seen;
    exp_addr.push_back(8'h7E); exp_addr.push_back(8'h7F); exp_addr.push_back(8'h80);
    exp_rdata.push_back(8'h81); exp_rdata.push_back(8'h80); exp_rdata.push_back(8'h7F);
    issue_start(1'b1, 8'h7E, 4'd3);
    wait_done(n);
    tests++;
    if (n != 37) begin
      fails++;
      $display("[TB] FAIL read3_latency: done at k+%0d expected k+37", n);
    end
    @(negedge clk);
    tests++;
    if (rv_seen - rv0 != 3) begin
      fails++;
      $display("[TB] FAIL read3_count: got %0d rdata_valid pulses expected 3", rv_seen - rv0);
    end
  endtask

  task automatic test_write_wrap();
    int n;
    wsrc.push_back(8'h11); wsrc.push_back(8'h22);
    exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
    exp_wdata.push_back(8'h11); exp_wdata.push_back(8'h22);
    issue_start(1'b0, 8'hFF, 4'd2);
    wait_done(n);
    tests++;
    if (n != 25) begin
      fails++;
      $display("[TB] FAIL wrap_latency: done at k+%0d expected k+25", n);
    end
    @(negedge clk);
    tests++;
    if (model_mem[8'hFF] !== 8'h11 || model_mem[8'h00] !== 8'h22) begin
      fails++;
      $display("[TB] FAIL wrap_regs: reg[ff]=%h reg[00]=%h expected 11 22",
               model_mem[8'hFF], model_mem[8'h00]);
    end
  endtask

  task automatic test_len_zero_and_ignored_start();
    int n, d0, i;
    exp_addr.push_back(8'h40);
    exp_rdata.push_back(8'hBF);
    issue_start(1'b1, 8'h40, 4'd0);
    wait_done(n);
    tests++;
    if (n != 13) begin
      fails++;
      $display("[TB] FAIL len0_latency: done at k+%0d expected k+13", n);
    end
    repeat (2) @(negedge clk);
    d0 = done_seen;
    wsrc.push_back(8'h3C);
    exp_addr.push_back(8'h50);
    exp_wdata.push_back(8'h3C);
    issue_start(1'b0, 8'h50, 4'd1);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b1; addr = 8'h90; burst_len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (done !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    tests++;
    if (done_seen - d0 != 1) begin
      fails++;
      $display("[TB] FAIL ignored_start_done: got %0d done pulses expected 1", done_seen - d0);
    end
    tests++;
    if (busy !== 1'b0 || model_mem[8'h50] !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL ignored_start_state: busy=%b reg[50]=%h expected 0 3c",
               busy, model_mem[8'h50]);
    end
  endtask

  task automatic test_reset_mid_write();
    int n, d0, i;
    width_en = 1'b0;
    wsrc.push_back(8'h77);
    exp_addr.push_back(8'h30);
    exp_wdata.push_back(8'h77);
    issue_start(1'b0, 8'h30, 4'd1);
    i = 0;
    while (wdata_ack !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    tests++;
    if (wdata_ack !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_ack_timeout: wdata_ack=%b expected 1", wdata_ack);
    end
    @(negedge clk);
    reset = 1'b1;
    d0 = done_seen;
    @(negedge clk);
    tests++;
    if ({AD, CS, WR, RD, busy, done} !== 6'b111100) begin
      fails++;
      $display("[TB] FAIL abort_outputs: AD CS WR RD busy done=%b expected 111100",
               {AD, CS, WR, RD, busy, done});
    end
    tests++;
    if (salient !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL abort_bus: got %h expected released (ff)", salient);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (done_seen != d0 || rdata !== 8'h00) begin
      fails++;
      $display("[TB] FAIL abort_no_done: extra done=%0d rdata=%h expected 0 00",
               done_seen - d0, rdata);
    end
    width_en = 1'b1;
    wsrc.push_back(8'h66);
    exp_addr.push_back(8'h31);
    exp_wdata.push_back(8'h66);
    issue_start(1'b0, 8'h31, 4'd1);
    wait_done(n);
    tests++;
    if (n != 13) begin
      fails++;
      $display("[TB] FAIL restart_latency: done at k+%0d expected k+13", n);
    end
    @(negedge clk);
    tests++;
    if (model_mem[8'h31] !== 8'h66) begin
      fails++;
      $display("[TB] FAIL restart_reg: reg[31]=%h expected 66", model_mem[8'h31]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_write_wrap();
    test_len_zero_and_ignored_start();
    test_reset_mid_write();
    repeat (4) @(negedge clk);
    tests++;
    if (exp_addr.size() != 0 || exp_wdata.size() != 0 || exp_rdata.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: left addr=%0d wdata=%0d rdata=%0d expected 0 0 0",
               exp_addr.size(), exp_wdata.size(), exp_rdata.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
